// File: rtl/enc_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// enc_ctrl_unit_if
// Request/response bundle between the AES top-level controller, the key
// schedule, the round datapath and the encryption controller.
//
// Ports (by modport):
//   master : drives start_op, ed_sel, r_ready, key_op, key_expanded, data_in,
//            mk_key; observes every controller output.
//   slave  : the controller side (enc_ctrl_unit); mirror of master.
//
// Parameters:
//   NUM_ROUNDS  number of cipher rounds; sets the round_num width.
// -----------------------------------------------------------------------------
interface enc_ctrl_unit_if #(
    parameter int NUM_ROUNDS = 10
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);

    logic          start_op;
    logic          ed_sel;
    logic          r_ready;
    logic          key_op;
    logic          key_expanded;
    logic [128:0]  data_in;
    logic [127:0]  mk_key;

    logic          start_key_exp;
    logic          round_en;
    logic [RW-1:0] round_num;
    logic          last_round;
    logic          enc_done;
    logic          busy;
    logic          enc_err;
    logic [128:0]  e_data;
    logic [127:0]  e_key;

    modport master (
        output start_op, ed_sel, r_ready, key_op, key_expanded, data_in, mk_key,
        input  start_key_exp, round_en, round_num, last_round, enc_done, busy,
               enc_err, e_data, e_key
    );

    modport slave (
        input  start_op, ed_sel, r_ready, key_op, key_expanded, data_in, mk_key,
        output start_key_exp, round_en, round_num, last_round, enc_done, busy,
               enc_err, e_data, e_key
    );
endinterface

// File: rtl/enc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// enc_ctrl_unit
// Encryption controller for the AES core. Accepts an encrypt request, captures
// the block and master key, kicks off key expansion, walks the round datapath
// through NUM_ROUNDS+1 round slots, waits for the output side, then holds
// enc_done until the top controller acknowledges with key_op.
//
// Ports:
//   clk    in  system clock, rising edge
//   n_rst  in  asynchronous active-low reset
//   bus    enc_ctrl_unit_if.slave
//            in : start_op, ed_sel, r_ready, key_op, key_expanded, data_in, mk_key
//            out: start_key_exp, round_en, round_num, last_round, enc_done,
//                 busy, enc_err, e_data, e_key
//
// Build option:
//   ENC_TIMEOUT_EN  when defined, KEY_EXP is guarded by a KEY_WAIT_MAX-cycle
//                   watchdog that routes through a one-cycle ERR state
//                   (enc_err=1). When undefined, KEY_EXP waits forever and
//                   enc_err is tied low.
//
// All outputs are decoded from registered state; no input reaches an output
// combinationally.
//
// State table
//   state      | meaning
//   S_IDLE     | waiting for start_op && ed_sel; outputs all 0
//   S_LOAD     | one cycle after capture; clears round counter
//   S_KEY_EXP  | start_key_exp on first cycle; wait for key_expanded
//   S_ROUND    | round_en, round_num 0..NUM_ROUNDS, one per cycle
//   S_OUT_WAIT | result ready, waiting for r_ready
//   S_DONE     | enc_done held until key_op
//   S_ERR      | (ENC_TIMEOUT_EN only) one-cycle enc_err, back to IDLE
// -----------------------------------------------------------------------------
module enc_ctrl_unit #(
    parameter int NUM_ROUNDS   = 10,
    parameter int KEY_WAIT_MAX = 64
) (
    input  logic           clk,
    input  logic           n_rst,
    enc_ctrl_unit_if.slave bus
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);

    if (NUM_ROUNDS < 1) begin : g_bad_rounds
        $error("NUM_ROUNDS must be at least 1");
    end
    if (KEY_WAIT_MAX < 2) begin : g_bad_wait
        $error("KEY_WAIT_MAX must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEY_EXP,
        S_ROUND,
        S_OUT_WAIT,
        S_DONE
`ifdef ENC_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [128:0]  data_q, data_d;
    logic [127:0]  key_q, key_d;
    // Set only on the cycle after LOAD, i.e. the first KEY_EXP cycle.
    logic          kexp_first_q, kexp_first_d;

`ifdef ENC_TIMEOUT_EN
    localparam int TW = $clog2(KEY_WAIT_MAX);
    localparam logic [TW-1:0] TMO_INIT = TW'(KEY_WAIT_MAX - 1);
    // Down-counter: loaded on LOAD, terminal count 0 marks the limit cycle.
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            round_q      <= '0;
            data_q       <= '0;
            key_q        <= '0;
            kexp_first_q <= 1'b0;
`ifdef ENC_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            data_q       <= data_d;
            key_q        <= key_d;
            kexp_first_q <= kexp_first_d;
`ifdef ENC_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        data_d       = data_q;
        key_d        = key_q;
        kexp_first_d = 1'b0;
`ifdef ENC_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start_op && bus.ed_sel) begin
                    state_d = S_LOAD;
                    data_d  = bus.data_in;
                    key_d   = bus.mk_key;
                end
            end
            S_LOAD: begin
                state_d      = S_KEY_EXP;
                round_d      = '0;
                kexp_first_d = 1'b1;
`ifdef ENC_TIMEOUT_EN
                tmo_d        = TMO_INIT;
`endif
            end
            S_KEY_EXP: begin
                // key_expanded has priority over the watchdog limit.
                if (bus.key_expanded) begin
                    state_d = S_ROUND;
`ifdef ENC_TIMEOUT_EN
                    tmo_d   = '0;
                end else if (tmo_q == '0) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d   = tmo_q - 1'b1;
`endif
                end
            end
            S_ROUND: begin
                if (round_q == RW'(NUM_ROUNDS)) begin
                    state_d = S_OUT_WAIT;
                    round_d = '0;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            S_OUT_WAIT: begin
                if (bus.r_ready) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.key_op) state_d = S_IDLE;
            end
`ifdef ENC_TIMEOUT_EN
            S_ERR: begin
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.start_key_exp = (state_q == S_KEY_EXP) && kexp_first_q;
    assign bus.round_en      = (state_q == S_ROUND);
    assign bus.round_num     = round_q;
    assign bus.last_round    = (state_q == S_ROUND) && (round_q == RW'(NUM_ROUNDS));
    assign bus.enc_done      = (state_q == S_DONE);
    assign bus.e_data        = (state_q != S_IDLE) ? data_q : '0;
    assign bus.e_key         = (state_q != S_IDLE) ? key_q : '0;
`ifdef ENC_TIMEOUT_EN
    assign bus.enc_err       = (state_q == S_ERR);
`else
    assign bus.enc_err       = 1'b0;
`endif

endmodule

// File: tb/tb_enc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_enc_ctrl_unit
// Directed bench for enc_ctrl_unit. Each accepted request that should finish
// pushes its expected block/key into sb_q; the monitor pops on every rising
// enc_done and compares e_data/e_key. Cycle-accurate sequencing is checked
// inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_enc_ctrl_unit;
    localparam int NR = 10;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    enc_ctrl_unit_if #(.NUM_ROUNDS(NR)) bus();

    enc_ctrl_unit #(.NUM_ROUNDS(NR), .KEY_WAIT_MAX(64)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [128:0] data;
        logic [127:0] key;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   err_cycles = 0;
    logic done_prev = 1'b0;

    localparam logic [128:0] D1 = 129'h1_00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [128:0] D2 = 129'h1_DEADBEEFDEADBEEFDEADBEEFDEADBEEF;
    localparam logic [128:0] D3 = 129'h1_0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] K3 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [128:0] D4 = 129'h0_A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    localparam logic [127:0] K4 = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
    localparam logic [128:0] D5 = 129'h1_3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] K5 = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [128:0] D6 = 129'h1_11111111222222223333333344444444;
    localparam logic [127:0] K6 = 128'h55555555666666667777777788888888;
    localparam logic [128:0] D7 = 129'h0_99999999AAAAAAAABBBBBBBBCCCCCCCC;
    localparam logic [127:0] K7 = 128'hDDDDDDDDEEEEEEEEFFFFFFFF00000000;
    localparam logic [128:0] D8 = 129'h1_CAFEBABECAFEBABECAFEBABECAFEBABE;
    localparam logic [127:0] K8 = 128'h0123456789ABCDEF0123456789ABCDEF;

    task automatic chk(string name, logic [128:0] act, logic [128:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; afterwards the DUT is in cycle 1 (LOAD).
    task automatic start(logic [128:0] d, logic [127:0] k, bit push);
        exp_t e;
        bus.start_op = 1'b1;
        bus.ed_sel   = 1'b1;
        bus.data_in  = d;
        bus.mk_key   = k;
        if (push) begin
            e.data = d;
            e.key  = k;
            sb_q.push_back(e);
        end
        tick();
        bus.start_op = 1'b0;
        bus.data_in  = '0;
        bus.mk_key   = '0;
    endtask

    // From cycle 1 with r_ready=1: run to DONE, check, acknowledge.
    task automatic complete_op(string tag);
        tick();
        bus.key_expanded = 1'b1;
        tick();
        bus.key_expanded = 1'b0;
        repeat (NR + 1) tick();
        tick();
        chk({tag, "_done"}, bus.enc_done, 1);
        bus.key_op = 1'b1;
        tick();
        bus.key_op = 1'b0;
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    // Scoreboard monitor: one pop per rising enc_done.
    always @(negedge clk) begin
        exp_t e;
        if (bus.enc_err) err_cycles++;
        if (bus.enc_done && !done_prev) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: enc_done with no expected entry, e_data %h", bus.e_data);
            end else begin
                e = sb_q.pop_front();
                chk("sb_e_data", bus.e_data, e.data);
                chk("sb_e_key", {1'b0, bus.e_key}, {1'b0, e.key});
            end
        end
        done_prev = bus.enc_done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_op     = 1'b0;
        bus.ed_sel       = 1'b0;
        bus.r_ready      = 1'b0;
        bus.key_op       = 1'b0;
        bus.key_expanded = 1'b0;
        bus.data_in      = '0;
        bus.mk_key       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.enc_done, 0);
        chk("rst_err", bus.enc_err, 0);
        chk("rst_skx", bus.start_key_exp, 0);
        chk("rst_round_en", bus.round_en, 0);
        chk("rst_e_data", bus.e_data, 0);
        n_rst = 1'b1;
        tick();

        // 2: decrypt request ignored
        bus.start_op = 1'b1;
        bus.ed_sel   = 1'b0;
        bus.data_in  = D2;
        bus.mk_key   = K1;
        tick();
        bus.start_op = 1'b0;
        chk("t2_busy", bus.busy, 0);
        chk("t2_e_data", bus.e_data, 0);
        chk("t2_skx", bus.start_key_exp, 0);
        tick();
        chk("t2_busy_later", bus.busy, 0);

        // 1: nominal cycle-accurate run
        bus.r_ready = 1'b1;
        start(D1, K1, 1);
        chk("t1_load_busy", bus.busy, 1);
        chk("t1_load_skx", bus.start_key_exp, 0);
        chk("t1_load_e_data", bus.e_data, D1);
        tick();
        chk("t1_kexp_skx", bus.start_key_exp, 1);
        chk("t1_kexp_round_en", bus.round_en, 0);
        chk("t1_kexp_e_key", {1'b0, bus.e_key}, {1'b0, K1});
        bus.key_expanded = 1'b1;
        tick();
        bus.key_expanded = 1'b0;
        chk("t1_skx_one_cycle", bus.start_key_exp, 0);
        for (int c = 3; c <= 13; c++) begin
            chk("t1_round_en", bus.round_en, 1);
            chk("t1_round_num", bus.round_num, c - 3);
            chk("t1_last_round", bus.last_round, (c == 13));
            tick();
        end
        chk("t1_ow_round_en", bus.round_en, 0);
        chk("t1_ow_round_num", bus.round_num, 0);
        chk("t1_ow_done", bus.enc_done, 0);
        chk("t1_ow_busy", bus.busy, 1);
        tick();
        chk("t1_done_c15", bus.enc_done, 1);
        bus.key_op = 1'b1;
        tick();
        bus.key_op = 1'b0;
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_done", bus.enc_done, 0);
        chk("t1_idle_e_data", bus.e_data, 0);

        // 3: output side stalls for 20 cycles
        bus.r_ready = 1'b0;
        start(D3, K3, 1);
        tick();
        bus.key_expanded = 1'b1;
        tick();
        bus.key_expanded = 1'b0;
        repeat (NR + 1) tick();
        for (int i = 0; i < 20; i++) begin
            chk("t3_wait_done", bus.enc_done, 0);
            chk("t3_wait_busy", bus.busy, 1);
            bus.key_op = (i == 10);
            tick();
        end
        bus.key_op = 1'b0;
        chk("t3_keyop_ignored", bus.busy, 1);
        bus.r_ready = 1'b1;
        tick();
        chk("t3_done", bus.enc_done, 1);
        repeat (3) tick();
        chk("t3_done_held", bus.enc_done, 1);
        bus.key_op = 1'b1;
        tick();
        bus.key_op = 1'b0;
        chk("t3_idle", bus.busy, 0);

        // 4: reset during ROUND at round_num 5, then a fresh request
        start(D4, K4, 1);
        tick();
        bus.key_expanded = 1'b1;
        tick();
        bus.key_expanded = 1'b0;
        repeat (5) tick();
        chk("t4_round5", bus.round_num, 5);
        n_rst = 1'b0;
        #1;
        chk("t4_rst_busy", bus.busy, 0);
        chk("t4_rst_round_en", bus.round_en, 0);
        chk("t4_rst_round_num", bus.round_num, 0);
        chk("t4_rst_e_data", bus.e_data, 0);
        sb_q.delete();
        #3;
        n_rst = 1'b1;
        tick();
        start(D5, K5, 1);
        chk("t4_new_accept", bus.busy, 1);
        complete_op("t4");

        // 5: start_op during ROUND is ignored
        start(D6, K6, 1);
        tick();
        bus.key_expanded = 1'b1;
        tick();
        bus.key_expanded = 1'b0;
        repeat (4) tick();
        bus.start_op = 1'b1;
        bus.ed_sel   = 1'b1;
        bus.data_in  = D7;
        bus.mk_key   = K7;
        tick();
        bus.start_op = 1'b0;
        chk("t5_e_data", bus.e_data, D6);
        chk("t5_e_key", {1'b0, bus.e_key}, {1'b0, K6});
        chk("t5_round_num", bus.round_num, 5);
        repeat (6) tick();
        tick();
        chk("t5_done", bus.enc_done, 1);
        bus.key_op = 1'b1;
        tick();
        bus.key_op = 1'b0;
        bus.data_in = '0;
        bus.mk_key  = '0;

        // 6: key expansion never completes
        start(D8, K8, 0);
        tick();
`ifdef ENC_TIMEOUT_EN
        repeat (63) tick();
        chk("t6_limit_err", bus.enc_err, 0);
        chk("t6_limit_busy", bus.busy, 1);
        tick();
        chk("t6_err", bus.enc_err, 1);
        chk("t6_err_busy", bus.busy, 1);
        tick();
        chk("t6_err_clear", bus.enc_err, 0);
        chk("t6_idle", bus.busy, 0);
        chk("t6_err_cycles", err_cycles, 1);
`else
        repeat (100) tick();
        chk("t6_still_busy", bus.busy, 1);
        chk("t6_no_err", bus.enc_err, 0);
        chk("t6_no_round", bus.round_en, 0);
        chk("t6_err_cycles", err_cycles, 0);
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        tick();
        chk("t6_rst_idle", bus.busy, 0);
`endif

        tick();
        chk("sb_empty", sb_q.size(), 0);
        chk("done_count", n_done, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
